// File: rtl/three_port_ram_ctrl_if.sv
// Bus bundle for three_port_ram_ctrl: write requesters, RAM write port and both read ports.
// Handshake: a requester raises WrReq_SI[i] and holds WrAddr_DI[i]/WrData_DI[i] until WrGnt_SO[i];
// the cycle where both are high completes exactly one write. InitReq_SI is a single-cycle pulse.
interface three_port_ram_ctrl_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 4
);
   logic                                  InitReq_SI;
   logic                                  InitBusy_SO;
   logic [NUM_REQ-1:0]                    WrReq_SI;
   logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    WrAddr_DI;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    WrData_DI;
   logic [NUM_REQ-1:0]                    WrGnt_SO;
   logic                                  RamWrEn_SO;
   logic [ADDR_WIDTH-1:0]                 RamWrAddr_DO;
   logic [DATA_WIDTH-1:0]                 RamWrData_DO;
   logic [ADDR_WIDTH-1:0]                 RdAddr_DI_0;
   logic [ADDR_WIDTH-1:0]                 RdAddr_DI_1;
   logic [DATA_WIDTH-1:0]                 RdData_DO_0;
   logic [DATA_WIDTH-1:0]                 RdData_DO_1;
   logic [ADDR_WIDTH-1:0]                 RamRdAddr_DO_0;
   logic [ADDR_WIDTH-1:0]                 RamRdAddr_DO_1;
   logic [DATA_WIDTH-1:0]                 RamRdData_DI_0;
   logic [DATA_WIDTH-1:0]                 RamRdData_DI_1;

   modport slave (
      input  InitReq_SI, WrReq_SI, WrAddr_DI, WrData_DI,
      input  RdAddr_DI_0, RdAddr_DI_1, RamRdData_DI_0, RamRdData_DI_1,
      output InitBusy_SO, WrGnt_SO, RamWrEn_SO, RamWrAddr_DO, RamWrData_DO,
      output RdData_DO_0, RdData_DO_1, RamRdAddr_DO_0, RamRdAddr_DO_1
   );

   modport master (
      output InitReq_SI, WrReq_SI, WrAddr_DI, WrData_DI,
      output RdAddr_DI_0, RdAddr_DI_1, RamRdData_DI_0, RamRdData_DI_1,
      input  InitBusy_SO, WrGnt_SO, RamWrEn_SO, RamWrAddr_DO, RamWrData_DO,
      input  RdData_DO_0, RdData_DO_1, RamRdAddr_DO_0, RamRdAddr_DO_1
   );
endinterface

// File: rtl/three_port_ram_ctrl.sv
// Round-robin write arbiter plus zero-fill sweep in front of a 1W/2R RAM.
// Define THREE_PORT_RAM_CTRL_BYPASS_EN to forward same-cycle write data onto the read ports.
module three_port_ram_ctrl #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_DEPTH = 1024,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 4
) (
   input  logic                  Clk_CI,
   input  logic                  Rst_RI,
   three_port_ram_ctrl_if.slave  bus,
   output logic                  StateDbg_SO
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);
   localparam logic [PTR_W-1:0]      LAST_REQ  = PTR_W'(NUM_REQ - 1);

   typedef enum logic {IDLE = 1'b0, INIT = 1'b1} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic [PTR_W-1:0]        ptr_q, ptr_d;

   logic                    gnt_vld;
   logic [PTR_W-1:0]        gnt_idx;
   logic [NUM_REQ-1:0]      gnt;
   logic                    wr_en;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [DATA_WIDTH-1:0]   wr_data;

   // Scan requesters starting at the priority pointer; first hit wins.
   always_comb begin : arb
      int               idx;
      logic [PTR_W-1:0] cand;
      gnt_vld = 1'b0;
      gnt_idx = ptr_q;
      idx     = 0;
      cand    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         cand = PTR_W'(idx);
         if (!gnt_vld && bus.WrReq_SI[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   always_comb begin : fsm
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      gnt     = '0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      case (state_q)
         IDLE: begin
            if (gnt_vld) begin
               gnt[gnt_idx] = 1'b1;
               wr_en        = 1'b1;
               wr_addr      = bus.WrAddr_DI[gnt_idx];
               wr_data      = bus.WrData_DI[gnt_idx];
               ptr_d        = (gnt_idx == LAST_REQ) ? '0 : gnt_idx + 1'b1;
            end
            // A grant in the same cycle is still served; the sweep starts next cycle.
            if (bus.InitReq_SI) begin
               state_d = INIT;
               cnt_d   = '0;
            end
         end
         INIT: begin
            wr_en   = 1'b1;
            wr_addr = cnt_q;
            if (cnt_q == LAST_ADDR) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Grant path is combinational, so silence it while reset is held.
      if (Rst_RI) begin
         gnt   = '0;
         wr_en = 1'b0;
      end
   end

   always_ff @(posedge Clk_CI or posedge Rst_RI) begin
      if (Rst_RI) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus.InitBusy_SO    = (state_q == INIT);
   assign bus.WrGnt_SO       = gnt;
   assign bus.RamWrEn_SO     = wr_en;
   assign bus.RamWrAddr_DO   = wr_addr;
   assign bus.RamWrData_DO   = wr_data;
   assign bus.RamRdAddr_DO_0 = bus.RdAddr_DI_0;
   assign bus.RamRdAddr_DO_1 = bus.RdAddr_DI_1;
   assign StateDbg_SO        = state_q;

`ifdef THREE_PORT_RAM_CTRL_BYPASS_EN
   assign bus.RdData_DO_0 = (wr_en && (wr_addr == bus.RdAddr_DI_0)) ? wr_data : bus.RamRdData_DI_0;
   assign bus.RdData_DO_1 = (wr_en && (wr_addr == bus.RdAddr_DI_1)) ? wr_data : bus.RamRdData_DI_1;
`else
   assign bus.RdData_DO_0 = bus.RamRdData_DI_0;
   assign bus.RdData_DO_1 = bus.RamRdData_DI_1;
`endif

endmodule

// File: tb/tb_three_port_ram_ctrl.sv
// Bench for three_port_ram_ctrl: bench-side RAM, behavioural reference model, scenario tasks.
module tb_three_port_ram_ctrl;
  localparam int AW = 8;
  localparam int DD = 16;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int IW = $clog2(DD);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dbg_state;
  logic init_req = 1'b0;
  logic [NR-1:0] req = '0;
  logic [NR-1:0][AW-1:0] waddr = '0;
  logic [NR-1:0][DW-1:0] wdata = '0;
  logic [AW-1:0] rd0 = '0;
  logic [AW-1:0] rd1 = '0;
  logic ram_load = 1'b1;
  logic [DW-1:0] ram [2**AW];

  int n_chk = 0;
  int n_pass = 0;

  // reference model state
  int m_ptr = 0;
  bit m_busy = 1'b0;
  int m_cnt = 0;
  logic [DW-1:0] m_mem [DD];
  logic [NR-1:0] e_gnt;
  logic e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  int e_g = -1;

  always #5 clk = ~clk;

  three_port_ram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  three_port_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_DEPTH(DD), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .Clk_CI(clk),
    .Rst_RI(rst),
    .bus(bus),
    .StateDbg_SO(dbg_state)
  );

  assign bus.InitReq_SI     = init_req;
  assign bus.WrReq_SI       = req;
  assign bus.WrAddr_DI      = waddr;
  assign bus.WrData_DI      = wdata;
  assign bus.RdAddr_DI_0    = rd0;
  assign bus.RdAddr_DI_1    = rd1;
  assign bus.RamRdData_DI_0 = ram[bus.RamRdAddr_DO_0];
  assign bus.RamRdData_DI_1 = ram[bus.RamRdAddr_DO_1];

  function automatic logic [DW-1:0] init_val(input int i);
    return (DW'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 2**AW; i++) ram[i] <= init_val(i);
    end else if (bus.RamWrEn_SO) begin
      ram[bus.RamWrAddr_DO] <= bus.RamWrData_DO;
    end
  end

  function automatic void model_reset();
    m_ptr = 0;
    m_busy = 1'b0;
    m_cnt = 0;
    e_g = -1;
  endfunction

  // Expected write-port behaviour for the current inputs: the requester closest after the pointer wins.
  function automatic void model_expect();
    int best;
    int d;
    e_gnt = '0; e_we = 1'b0; e_addr = '0; e_data = '0; e_g = -1;
    if (m_busy) begin
      e_we = 1'b1;
      e_addr = AW'(m_cnt);
    end else begin
      best = NR;
      for (int i = 0; i < NR; i++) begin
        d = (i - m_ptr + NR) % NR;
        if (req[i] && d < best) begin
          best = d;
          e_g = i;
        end
      end
      if (e_g >= 0) begin
        e_gnt[e_g] = 1'b1;
        e_we = 1'b1;
        e_addr = waddr[e_g];
        e_data = wdata[e_g];
      end
    end
  endfunction

  function automatic void model_commit(input bit init_in);
    if (m_busy) begin
      m_mem[m_cnt] = '0;
      if (m_cnt == DD - 1) begin
        m_busy = 1'b0;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      if (e_g >= 0) begin
        m_mem[waddr[e_g][IW-1:0]] = wdata[e_g];
        m_ptr = (e_g + 1) % NR;
      end
      if (init_in) begin
        m_busy = 1'b1;
        m_cnt = 0;
      end
    end
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
`ifdef THREE_PORT_RAM_CTRL_BYPASS_EN
    if (e_we && e_addr == a) return e_data;
`endif
    return m_mem[a[IW-1:0]];
  endfunction

  function automatic void refresh(input int i);
    waddr[i] = AW'($urandom_range(0, DD - 1));
    wdata[i] = $urandom();
  endfunction

  // Advance to the next drive point; a requester granted last cycle gets fresh address/data.
  task automatic step_in();
    @(negedge clk);
    if (e_g >= 0) refresh(e_g);
  endtask

  task automatic test_reset();
    rst = 1'b1; ram_load = 1'b1; req = '1; init_req = 1'b0;
    for (int i = 0; i < NR; i++) refresh(i);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_chk++; if (bus.InitBusy_SO !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.InitBusy_SO); else n_pass++;
    n_chk++; if (bus.WrGnt_SO !== '0) $display("FAIL reset_gnt: got %b want 0000", bus.WrGnt_SO); else n_pass++;
    n_chk++; if (bus.RamWrEn_SO !== 1'b0) $display("FAIL reset_we: got %b want 0", bus.RamWrEn_SO); else n_pass++;
    n_chk++; if (dbg_state !== 1'b0) $display("FAIL reset_state: got %b want 0", dbg_state); else n_pass++;
    for (int i = 0; i < DD; i++) m_mem[i] = init_val(i);
    model_reset();
    @(negedge clk);
    rst = 1'b0; ram_load = 1'b0; req = '0;
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < 8; c++) begin
      step_in();
      req = '1; init_req = 1'b0;
      #1; model_expect();
      n_chk++; if (bus.WrGnt_SO !== (NR'(1) << (c % NR))) $display("FAIL rr_order c=%0d: got %b want %b", c, bus.WrGnt_SO, NR'(1) << (c % NR)); else n_pass++;
      n_chk++; if (bus.RamWrEn_SO !== 1'b1 || bus.RamWrAddr_DO !== e_addr || bus.RamWrData_DO !== e_data)
        $display("FAIL rr_write c=%0d: got en=%b a=%h d=%h want en=1 a=%h d=%h", c, bus.RamWrEn_SO, bus.RamWrAddr_DO, bus.RamWrData_DO, e_addr, e_data);
      else n_pass++;
      model_commit(1'b0);
    end
  endtask

  task automatic test_random();
    int pg;
    for (int c = 0; c < 40; c++) begin
      pg = e_g;
      step_in();
      init_req = 1'b0;
      for (int i = 0; i < NR; i++) if (!req[i] || i == pg) req[i] = 1'($urandom_range(0, 1));
      rd0 = AW'($urandom_range(0, DD - 1));
      rd1 = AW'($urandom_range(0, DD - 1));
      if ($urandom_range(0, 1) == 1) rd0 = waddr[$urandom_range(0, NR - 1)];
      #1; model_expect();
      n_chk++; if (bus.WrGnt_SO !== e_gnt) $display("FAIL rnd_gnt c=%0d: got %b want %b", c, bus.WrGnt_SO, e_gnt); else n_pass++;
      n_chk++; if (bus.RamWrEn_SO !== e_we) $display("FAIL rnd_we c=%0d: got %b want %b", c, bus.RamWrEn_SO, e_we); else n_pass++;
      if (e_we) begin
        n_chk++; if (bus.RamWrAddr_DO !== e_addr || bus.RamWrData_DO !== e_data)
          $display("FAIL rnd_wdata c=%0d: got a=%h d=%h want a=%h d=%h", c, bus.RamWrAddr_DO, bus.RamWrData_DO, e_addr, e_data);
        else n_pass++;
      end
      n_chk++; if (bus.RamRdAddr_DO_0 !== rd0 || bus.RamRdAddr_DO_1 !== rd1)
        $display("FAIL rnd_rdaddr c=%0d: got %h/%h want %h/%h", c, bus.RamRdAddr_DO_0, bus.RamRdAddr_DO_1, rd0, rd1);
      else n_pass++;
      n_chk++; if (bus.RdData_DO_0 !== exp_rd(rd0)) $display("FAIL rnd_rd0 c=%0d: got %h want %h", c, bus.RdData_DO_0, exp_rd(rd0)); else n_pass++;
      n_chk++; if (bus.RdData_DO_1 !== exp_rd(rd1)) $display("FAIL rnd_rd1 c=%0d: got %h want %h", c, bus.RdData_DO_1, exp_rd(rd1)); else n_pass++;
      model_commit(1'b0);
    end
  endtask

  task automatic test_init_sweep();
    step_in();
    req = '0; init_req = 1'b1;
    #1; model_expect();
    n_chk++; if (bus.InitBusy_SO !== 1'b0 || bus.RamWrEn_SO !== 1'b0)
      $display("FAIL sweep_start: got busy=%b en=%b want 0/0", bus.InitBusy_SO, bus.RamWrEn_SO);
    else n_pass++;
    model_commit(1'b1);
    for (int k = 0; k < DD; k++) begin
      step_in();
      init_req = 1'b0; req = 4'b0010;
      rd0 = AW'($urandom_range(0, DD - 1));
      #1; model_expect();
      n_chk++; if (bus.InitBusy_SO !== 1'b1) $display("FAIL sweep_busy k=%0d: got %b want 1", k, bus.InitBusy_SO); else n_pass++;
      n_chk++; if (bus.WrGnt_SO !== '0) $display("FAIL sweep_gnt k=%0d: got %b want 0000", k, bus.WrGnt_SO); else n_pass++;
      n_chk++; if (bus.RamWrEn_SO !== 1'b1 || bus.RamWrAddr_DO !== AW'(k) || bus.RamWrData_DO !== '0)
        $display("FAIL sweep_write k=%0d: got en=%b a=%h d=%h want en=1 a=%h d=0", k, bus.RamWrEn_SO, bus.RamWrAddr_DO, bus.RamWrData_DO, AW'(k));
      else n_pass++;
      n_chk++; if (bus.RdData_DO_0 !== exp_rd(rd0)) $display("FAIL sweep_rd0 k=%0d: got %h want %h", k, bus.RdData_DO_0, exp_rd(rd0)); else n_pass++;
      model_commit(1'b0);
    end
    step_in();
    #1; model_expect();
    n_chk++; if (bus.InitBusy_SO !== 1'b0) $display("FAIL sweep_end_busy: got %b want 0", bus.InitBusy_SO); else n_pass++;
    n_chk++; if (bus.WrGnt_SO !== 4'b0010) $display("FAIL sweep_end_gnt: got %b want 0010", bus.WrGnt_SO); else n_pass++;
    model_commit(1'b0);
  endtask

  task automatic test_reset_mid_sweep();
    step_in();
    init_req = 1'b0; req = 4'b0100;
    #1; model_expect();
    n_chk++; if (bus.WrGnt_SO !== 4'b0100) $display("FAIL mid_pre_gnt: got %b want 0100", bus.WrGnt_SO); else n_pass++;
    model_commit(1'b0);
    step_in();
    req = '0; init_req = 1'b1;
    #1; model_expect(); model_commit(1'b1);
    for (int k = 0; k < 8; k++) begin
      step_in();
      init_req = 1'b0; req = '1;
      #1;
      n_chk++; if (bus.WrGnt_SO !== '0 || bus.RamWrAddr_DO !== AW'(k))
        $display("FAIL mid_sweep k=%0d: got gnt=%b a=%h want 0000/%h", k, bus.WrGnt_SO, bus.RamWrAddr_DO, AW'(k));
      else n_pass++;
      if (k < 7) begin
        model_expect(); model_commit(1'b0);
      end
    end
    rst = 1'b1;
    #1;
    n_chk++; if (bus.InitBusy_SO !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", bus.InitBusy_SO); else n_pass++;
    n_chk++; if (bus.RamWrEn_SO !== 1'b0) $display("FAIL mid_rst_we: got %b want 0", bus.RamWrEn_SO); else n_pass++;
    n_chk++; if (bus.WrGnt_SO !== '0) $display("FAIL mid_rst_gnt: got %b want 0000", bus.WrGnt_SO); else n_pass++;
    model_reset();
    for (int c = 0; c < NR; c++) begin
      step_in();
      rst = 1'b0; req = '1;
      #1; model_expect();
      n_chk++; if (bus.InitBusy_SO !== 1'b0 || dbg_state !== 1'b0)
        $display("FAIL mid_post_idle c=%0d: got busy=%b state=%b want 0/0", c, bus.InitBusy_SO, dbg_state);
      else n_pass++;
      n_chk++; if (bus.WrGnt_SO !== (NR'(1) << c)) $display("FAIL mid_post_gnt c=%0d: got %b want %b", c, bus.WrGnt_SO, NR'(1) << c); else n_pass++;
      model_commit(1'b0);
    end
  endtask

  task automatic test_init_with_req();
    step_in();
    req = 4'b0100; init_req = 1'b1;
    #1; model_expect();
    n_chk++; if (bus.WrGnt_SO !== 4'b0100 || bus.InitBusy_SO !== 1'b0)
      $display("FAIL iwr_gnt: got gnt=%b busy=%b want 0100/0", bus.WrGnt_SO, bus.InitBusy_SO);
    else n_pass++;
    n_chk++; if (bus.RamWrEn_SO !== 1'b1 || bus.RamWrAddr_DO !== waddr[2] || bus.RamWrData_DO !== wdata[2])
      $display("FAIL iwr_write: got en=%b a=%h d=%h want en=1 a=%h d=%h", bus.RamWrEn_SO, bus.RamWrAddr_DO, bus.RamWrData_DO, waddr[2], wdata[2]);
    else n_pass++;
    model_commit(1'b1);
    for (int k = 0; k < DD; k++) begin
      step_in();
      req = '0; init_req = (k == 5);
      #1; model_expect();
      n_chk++; if (bus.InitBusy_SO !== 1'b1 || bus.RamWrAddr_DO !== AW'(k))
        $display("FAIL iwr_sweep k=%0d: got busy=%b a=%h want 1/%h", k, bus.InitBusy_SO, bus.RamWrAddr_DO, AW'(k));
      else n_pass++;
      model_commit(init_req);
    end
    for (int c = 0; c < 2; c++) begin
      step_in();
      init_req = 1'b0;
      #1; model_expect();
      n_chk++; if (bus.InitBusy_SO !== 1'b0 || dbg_state !== 1'b0)
        $display("FAIL iwr_no_requeue c=%0d: got busy=%b state=%b want 0/0", c, bus.InitBusy_SO, dbg_state);
      else n_pass++;
      model_commit(1'b0);
    end
  endtask

  task automatic test_forward();
    logic [DW-1:0] exp_fwd;
    step_in();
    init_req = 1'b0; req = 4'b0010;
    waddr[1] = AW'(5); wdata[1] = 32'hDEAD_BEEF;
    rd0 = AW'(5); rd1 = AW'(5);
    #1; model_expect();
`ifdef THREE_PORT_RAM_CTRL_BYPASS_EN
    exp_fwd = 32'hDEAD_BEEF;
`else
    exp_fwd = m_mem[5];
`endif
    n_chk++; if (bus.WrGnt_SO !== 4'b0010) $display("FAIL fwd_gnt: got %b want 0010", bus.WrGnt_SO); else n_pass++;
    n_chk++; if (bus.RdData_DO_0 !== exp_fwd) $display("FAIL fwd_rd0: got %h want %h", bus.RdData_DO_0, exp_fwd); else n_pass++;
    n_chk++; if (bus.RdData_DO_1 !== exp_fwd) $display("FAIL fwd_rd1: got %h want %h", bus.RdData_DO_1, exp_fwd); else n_pass++;
    model_commit(1'b0);
    step_in();
    req = '0; rd0 = AW'(6); rd1 = AW'(5);
    #1; model_expect();
    n_chk++; if (bus.RdData_DO_1 !== 32'hDEAD_BEEF) $display("FAIL fwd_after_rd1: got %h want deadbeef", bus.RdData_DO_1); else n_pass++;
    n_chk++; if (bus.RdData_DO_0 !== m_mem[6]) $display("FAIL fwd_after_rd0: got %h want %h", bus.RdData_DO_0, m_mem[6]); else n_pass++;
    model_commit(1'b0);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_random();
    test_init_sweep();
    test_reset_mid_sweep();
    test_init_with_req();
    test_forward();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/three_port_ram_ctrl.md
THREE_PORT_RAM_CTRL -- requirements
Module: three_port_ram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, RAM address width.
REQ-002 SHALL have parameter DATA_DEPTH, default 1024, number of RAM words; SHALL be <= 2**ADDR_WIDTH.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, RAM word width.
REQ-004 SHALL have parameter NUM_REQ, default 4, number of write requesters; SHALL be >= 2.
REQ-005 SHALL have port Clk_CI  in  1  single clock; all state on its rising edge.
REQ-006 SHALL have port Rst_RI  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port InitReq_SI  in  1  pulse: start zero-fill sweep.
REQ-008 SHALL have port InitBusy_SO  out  1  high while the sweep runs.
REQ-009 SHALL have port WrReq_SI  in  NUM_REQ  per-requester write request.
REQ-010 SHALL have port WrAddr_DI  in  NUM_REQ x ADDR_WIDTH  per-requester write address.
REQ-011 SHALL have port WrData_DI  in  NUM_REQ x DATA_WIDTH  per-requester write data.
REQ-012 SHALL have port WrGnt_SO  out  NUM_REQ  one-hot write grant.
REQ-013 SHALL have ports RamWrEn_SO / RamWrAddr_DO / RamWrData_DO  out  1 / ADDR_WIDTH / DATA_WIDTH  to RAM write port.
REQ-014 SHALL have ports RdAddr_DI_0, RdAddr_DI_1  in  ADDR_WIDTH  and RdData_DO_0, RdData_DO_1  out  DATA_WIDTH  user read ports.
REQ-015 SHALL have ports RamRdAddr_DO_0/1  out  ADDR_WIDTH  and RamRdData_DI_0/1  in  DATA_WIDTH  to RAM read ports.

Function
REQ-016 SHALL implement FSM states IDLE and INIT; IDLE->INIT when InitReq_SI=1 in IDLE; INIT->IDLE after writing address DATA_DEPTH-1.
REQ-017 SHALL in INIT drive RamWrEn_SO=1, RamWrData_DO=0, RamWrAddr_DO=sweep counter, counter 0..DATA_DEPTH-1 incrementing by 1 per cycle; sweep takes exactly DATA_DEPTH cycles.
REQ-018 SHALL ignore InitReq_SI while in INIT (no restart, no queuing); InitBusy_SO=1 exactly in INIT.
REQ-019 SHALL in INIT hold WrGnt_SO=0 regardless of WrReq_SI.
REQ-020 SHALL in IDLE grant combinationally, same cycle, exactly one requesting index chosen round-robin starting at priority pointer; WrGnt_SO=0 when no request.
REQ-021 SHALL in IDLE with a grant drive RamWrEn_SO=1 and the granted requester's WrAddr_DI/WrData_DI; write commits at that clock edge (zero-cycle latency).
REQ-022 SHALL after a grant to index i set priority pointer to (i+1) mod NUM_REQ; pointer unchanged when no grant.
REQ-023 SHALL require requesters to hold WrReq_SI, WrAddr_DI, WrData_DI stable until WrGnt_SO; a cycle with WrReq_SI=1 and WrGnt_SO=1 completes one write.
REQ-024 SHALL pass RdAddr_DI_x to RamRdAddr_DO_x and RamRdData_DI_x to RdData_DO_x combinationally, in both states.
REQ-025 SHALL, when InitReq_SI=1 and WrReq_SI!=0 in the same IDLE cycle, serve the grant that cycle and enter INIT next cycle.
REQ-026 SHALL drive RamWrEn_SO=0 in IDLE when no grant; RamWrAddr_DO/RamWrData_DO then don't-care.

Reset
REQ-027 SHALL on Rst_RI=1 immediately enter IDLE, clear sweep counter and priority pointer to 0, InitBusy_SO=0, WrGnt_SO=0, RamWrEn_SO=0.
REQ-028 SHALL abandon an in-progress sweep on reset; no resume after reset release.

Configuration
REQ-029 SHALL with macro THREE_PORT_RAM_CTRL_BYPASS_EN defined return RamWrData_DO on RdData_DO_x when RamWrEn_SO=1 and RdAddr_DI_x==RamWrAddr_DO (write-to-read forwarding, both ports independently).
REQ-030 SHALL without THREE_PORT_RAM_CTRL_BYPASS_EN return RamRdData_DI_x unconditionally (old data during write cycle).

Verification
REQ-031 SHALL cover: reset, WrReq_SI=4'b1111 held 8 cycles -> grants 0,1,2,3,0,1,2,3, one per cycle.
REQ-032 SHALL cover: DATA_DEPTH=16, InitReq_SI pulse -> InitBusy_SO high exactly 16 cycles, RamWrAddr_DO 0..15 with data 0, WrGnt_SO=0 throughout despite WrReq_SI=4'b0010.
REQ-033 SHALL cover: Rst_RI asserted mid-sweep at address 7 -> InitBusy_SO=0 and RamWrEn_SO=0 same cycle, IDLE after release, pointer 0.
REQ-034 SHALL cover: InitReq_SI with WrReq_SI=4'b0100 same cycle -> grant 2 that cycle, INIT next cycle; second InitReq_SI during INIT ignored.
REQ-035 SHALL cover: requester 1 writes 0xDEADBEEF to 0x05 while RdAddr_DI_0=0x05 -> RdData_DO_0=0xDEADBEEF that cycle with THREE_PORT_RAM_CTRL_BYPASS_EN, old RAM value without.
